// File: rtl/frame_write_arbiter.sv
// Frame-granular write-path arbiter: two 128-bit frame sources share one addr/data FIFO pair.
// Optional DOUBLE_BUFFER_EN offsets each frame into alternating buffers for the display reader.
module frame_write_arbiter #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned FRAME_WORDS = 115200,
  parameter int unsigned ADDR_SHIFT  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [1:0]            src_valid_in,
  input  logic [1:0]            src_last_in,
  input  logic [2*ADDR_W-1:0]   src_addr_in,
  input  logic [2*DATA_W-1:0]   src_data_in,
  output logic [1:0]            src_ready_out,
  input  logic                  addr_fifo_ready_in,
  input  logic                  data_fifo_ready_in,
  output logic                  addr_fifo_valid_out,
  output logic                  data_fifo_valid_out,
  output logic [ADDR_W-1:0]     addr_fifo_data_out,
  output logic [DATA_W-1:0]     data_fifo_data_out,
  output logic [1:0]            grant_out,
  output logic                  rd_buf_out,
  output logic                  frame_done_out
);

  localparam logic [ADDR_W-1:0] BUF1_OFS = ADDR_W'(FRAME_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                frame_done_q, frame_done_d;
  logic                fifo_rdy;
  logic                fire;
  logic                last_fire;
  logic                wr_buf;
  logic [ADDR_W-1:0]   own_addr;
  logic [ADDR_W-1:0]   addr_sum;

  // Both FIFOs must accept together; reset blocks any handshake in the same cycle.
  assign fifo_rdy = rst_in & addr_fifo_ready_in & data_fifo_ready_in;

  // Next-state, handshake and owner mux.
  always_comb begin
    state_d            = state_q;
    rr_d               = rr_q;
    fire               = 1'b0;
    last_fire          = 1'b0;
    own_addr           = '0;
    src_ready_out      = 2'b00;
    data_fifo_data_out = '0;
    unique case (state_q)
      IDLE: begin
        if (src_valid_in == 2'b11) begin
          state_d = rr_q ? OWN1 : OWN0;
        end else if (src_valid_in[0]) begin
          state_d = OWN0;
        end else if (src_valid_in[1]) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        fire               = src_valid_in[0] & fifo_rdy;
        last_fire          = fire & src_last_in[0];
        src_ready_out      = {1'b0, fire};
        own_addr           = src_addr_in[ADDR_W-1:0];
        data_fifo_data_out = src_data_in[DATA_W-1:0];
        if (last_fire) begin
          state_d = IDLE;
          rr_d    = 1'b1;
        end
      end
      OWN1: begin
        fire               = src_valid_in[1] & fifo_rdy;
        last_fire          = fire & src_last_in[1];
        src_ready_out      = {fire, 1'b0};
        own_addr           = src_addr_in[2*ADDR_W-1:ADDR_W];
        data_fifo_data_out = src_data_in[2*DATA_W-1:DATA_W];
        if (last_fire) begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_done_d = last_fire;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DOUBLE_BUFFER_EN
  logic wr_buf_q, wr_buf_d;
  logic rd_buf_q, rd_buf_d;

  // Swap buffers once a frame completes; display then reads the frame just written.
  always_comb begin
    wr_buf_d = wr_buf_q;
    rd_buf_d = rd_buf_q;
    if (last_fire) begin
      wr_buf_d = ~wr_buf_q;
      rd_buf_d = wr_buf_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_buf_q <= 1'b0;
      rd_buf_q <= 1'b1;
    end else begin
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  assign wr_buf     = wr_buf_q;
  assign rd_buf_out = rd_buf_q;
`else
  assign wr_buf     = 1'b0;
  assign rd_buf_out = 1'b0;
`endif

  assign addr_sum            = own_addr + (wr_buf ? BUF1_OFS : '0);
  assign addr_fifo_data_out  = (state_q == IDLE) ? '0 : (addr_sum << ADDR_SHIFT);
  assign addr_fifo_valid_out = fire;
  assign data_fifo_valid_out = fire;
  assign grant_out           = {state_q == OWN1, state_q == OWN0};
  assign frame_done_out      = frame_done_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Directed vector bench for frame_write_arbiter; expectations follow DOUBLE_BUFFER_EN.
module tb_frame_write_arbiter;

`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic         clk_in;
  logic         rst_in;
  logic [1:0]   src_valid_in;
  logic [1:0]   src_last_in;
  logic [53:0]  src_addr_in;
  logic [255:0] src_data_in;
  logic [1:0]   src_ready_out;
  logic         addr_fifo_ready_in;
  logic         data_fifo_ready_in;
  logic         addr_fifo_valid_out;
  logic         data_fifo_valid_out;
  logic [26:0]  addr_fifo_data_out;
  logic [127:0] data_fifo_data_out;
  logic [1:0]   grant_out;
  logic         rd_buf_out;
  logic         frame_done_out;

  int n_pass  = 0;
  int n_total = 0;

  frame_write_arbiter dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .src_valid_in        (src_valid_in),
    .src_last_in         (src_last_in),
    .src_addr_in         (src_addr_in),
    .src_data_in         (src_data_in),
    .src_ready_out       (src_ready_out),
    .addr_fifo_ready_in  (addr_fifo_ready_in),
    .data_fifo_ready_in  (data_fifo_ready_in),
    .addr_fifo_valid_out (addr_fifo_valid_out),
    .data_fifo_valid_out (data_fifo_valid_out),
    .addr_fifo_data_out  (addr_fifo_data_out),
    .data_fifo_data_out  (data_fifo_data_out),
    .grant_out           (grant_out),
    .rd_buf_out          (rd_buf_out),
    .frame_done_out      (frame_done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  l;
    logic [26:0] a0;
    logic [26:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        afr;
    logic        dfr;
    logic [1:0]  g;
    logic [1:0]  rdy;
    logic        fv;
    logic [26:0] ea;
    logic [31:0] ed;
    logic        rb;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  // Byte address of word a in buffer b1 (buffer 1 only exists with double buffering).
  function automatic logic [26:0] waddr(input bit b1, input int unsigned a);
    int unsigned s;
    s = a + ((DB && b1) ? 32'd115200 : 32'd0);
    return 27'(s * 32'd16);
  endfunction

  function automatic logic rbx(input logic x);
    return DB ? x : 1'b0;
  endfunction

  function automatic vec_t row(input logic rst, input logic [1:0] v, input logic [1:0] l,
                               input int unsigned a0, input int unsigned a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic afr, input logic dfr,
                               input logic [1:0] g, input logic [1:0] rdy, input logic fv,
                               input logic [26:0] ea, input logic [31:0] ed,
                               input logic rb, input logic dn);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.a0 = 27'(a0); r.a1 = 27'(a1);
    r.d0 = d0; r.d1 = d1; r.afr = afr; r.dfr = dfr;
    r.g = g; r.rdy = rdy; r.fv = fv; r.ea = ea; r.ed = ed; r.rb = rb; r.dn = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic apply(input vec_t r, input int idx);
    @(negedge clk_in);
    rst_in             = r.rst;
    src_valid_in       = r.v;
    src_last_in        = r.l;
    src_addr_in        = {r.a1, r.a0};
    src_data_in        = {{4{r.d1}}, {4{r.d0}}};
    addr_fifo_ready_in = r.afr;
    data_fifo_ready_in = r.dfr;
    #1;
    chk("grant",       idx, 128'(grant_out),           128'(r.g));
    chk("src_ready",   idx, 128'(src_ready_out),       128'(r.rdy));
    chk("addr_valid",  idx, 128'(addr_fifo_valid_out), 128'(r.fv));
    chk("data_valid",  idx, 128'(data_fifo_valid_out), 128'(r.fv));
    chk("addr_out",    idx, 128'(addr_fifo_data_out),  128'(r.ea));
    chk("data_out",    idx, data_fifo_data_out,        {4{r.ed}});
    chk("rd_buf",      idx, 128'(rd_buf_out),          128'(r.rb));
    chk("frame_done",  idx, 128'(frame_done_out),      128'(r.dn));
  endtask

  initial begin
    logic rbr;
    rbr = rbx(1'b1);
    rst_in = 1'b0; src_valid_in = 2'b00; src_last_in = 2'b00;
    src_addr_in = '0; src_data_in = '0;
    addr_fifo_ready_in = 1'b1; data_fifo_ready_in = 1'b1;
    repeat (2) @(posedge clk_in);

    // Reset state, then alternating 4-beat frames from both sources.
    vecs.push_back(row(0, 2'b11, 2'b00, 5, 20, 32'hA0, 32'hB0, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 5, 20, 32'hA0, 32'hB0, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 5, 20, 32'hA0, 32'hB0, 1, 1, 2'b01, 2'b01, 1, waddr(0, 5), 32'hA0, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 6, 20, 32'hA1, 32'hB0, 1, 1, 2'b01, 2'b01, 1, waddr(0, 6), 32'hA1, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 7, 20, 32'hA2, 32'hB0, 1, 1, 2'b01, 2'b01, 1, waddr(0, 7), 32'hA2, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b01, 8, 20, 32'hA3, 32'hB0, 1, 1, 2'b01, 2'b01, 1, waddr(0, 8), 32'hA3, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 8, 20, 32'hA3, 32'hB0, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbx(0), 1));
    vecs.push_back(row(1, 2'b11, 2'b00, 8, 20, 32'hA3, 32'hB0, 1, 1, 2'b10, 2'b10, 1, waddr(1, 20), 32'hB0, rbx(0), 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 8, 21, 32'hA3, 32'hB1, 1, 1, 2'b10, 2'b10, 1, waddr(1, 21), 32'hB1, rbx(0), 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 8, 22, 32'hA3, 32'hB2, 1, 1, 2'b10, 2'b10, 1, waddr(1, 22), 32'hB2, rbx(0), 0));
    vecs.push_back(row(1, 2'b11, 2'b10, 8, 23, 32'hA3, 32'hB3, 1, 1, 2'b10, 2'b10, 1, waddr(1, 23), 32'hB3, rbx(0), 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 5, 23, 32'hC0, 32'hB3, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbx(1), 1));
    vecs.push_back(row(1, 2'b11, 2'b00, 5, 23, 32'hC0, 32'hB3, 1, 1, 2'b01, 2'b01, 1, waddr(0, 5), 32'hC0, rbx(1), 0));
    // One FIFO not ready: nothing pushed, source stalled.
    vecs.push_back(row(1, 2'b01, 2'b00, 6, 23, 32'hC1, 32'hB3, 1, 0, 2'b01, 2'b00, 0, waddr(0, 6), 32'hC1, rbx(1), 0));
    vecs.push_back(row(1, 2'b01, 2'b00, 6, 23, 32'hC1, 32'hB3, 0, 1, 2'b01, 2'b00, 0, waddr(0, 6), 32'hC1, rbx(1), 0));
    vecs.push_back(row(1, 2'b01, 2'b00, 6, 23, 32'hC1, 32'hB3, 1, 1, 2'b01, 2'b01, 1, waddr(0, 6), 32'hC1, rbx(1), 0));
    // Owner idles mid-frame while the other source requests: grant held.
    vecs.push_back(row(1, 2'b10, 2'b00, 7, 30, 32'hC2, 32'hD0, 1, 1, 2'b01, 2'b00, 0, waddr(0, 7), 32'hC2, rbx(1), 0));
    vecs.push_back(row(1, 2'b10, 2'b00, 7, 30, 32'hC2, 32'hD0, 1, 1, 2'b01, 2'b00, 0, waddr(0, 7), 32'hC2, rbx(1), 0));
    vecs.push_back(row(1, 2'b10, 2'b00, 7, 30, 32'hC2, 32'hD0, 1, 1, 2'b01, 2'b00, 0, waddr(0, 7), 32'hC2, rbx(1), 0));
    vecs.push_back(row(1, 2'b11, 2'b01, 7, 30, 32'hC2, 32'hD0, 1, 1, 2'b01, 2'b01, 1, waddr(0, 7), 32'hC2, rbx(1), 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 7, 30, 32'hC2, 32'hD0, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbx(0), 1));
    vecs.push_back(row(1, 2'b11, 2'b00, 7, 30, 32'hC2, 32'hD0, 1, 1, 2'b10, 2'b10, 1, waddr(1, 30), 32'hD0, rbx(0), 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 7, 31, 32'hC2, 32'hD1, 1, 1, 2'b10, 2'b10, 1, waddr(1, 31), 32'hD1, rbx(0), 0));
    // Reset mid-frame, even with last asserted: no handshake, no swap, no done pulse.
    vecs.push_back(row(0, 2'b10, 2'b10, 7, 32, 32'hC2, 32'hD2, 1, 1, 2'b10, 2'b00, 0, waddr(1, 32), 32'hD2, rbx(0), 0));
    vecs.push_back(row(1, 2'b00, 2'b00, 7, 32, 32'hC2, 32'hD2, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbr, 0));
    // After reset the round-robin pointer favours src0 again.
    vecs.push_back(row(1, 2'b11, 2'b00, 9, 32, 32'hE0, 32'hD2, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b00, 9, 32, 32'hE0, 32'hD2, 1, 1, 2'b01, 2'b01, 1, waddr(0, 9), 32'hE0, rbr, 0));
    vecs.push_back(row(1, 2'b11, 2'b01, 10, 32, 32'hE1, 32'hD2, 1, 1, 2'b01, 2'b01, 1, waddr(0, 10), 32'hE1, rbr, 0));
    vecs.push_back(row(1, 2'b00, 2'b00, 10, 32, 32'hE1, 32'hD2, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbx(0), 1));
    vecs.push_back(row(0, 2'b00, 2'b00, 10, 32, 32'hE1, 32'hD2, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbx(0), 0));
    vecs.push_back(row(1, 2'b00, 2'b00, 10, 32, 32'hE1, 32'hD2, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbr, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Two single-beat src0 frames at word 5: second lands in buffer 1 when double buffered.
    for (int k = 0; k < 2; k++) begin
      logic rb_prev;
      rb_prev = (k == 0) ? rbr : rbx(0);
      apply(row(1, 2'b01, 2'b00, 5, 0, 32'hF0, 32'h0, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rb_prev, 0),
            100 + 3 * k);
      apply(row(1, 2'b01, 2'b01, 5, 0, 32'hF0 + 32'(k), 32'h0, 1, 1, 2'b01, 2'b01, 1,
                waddr(k == 1, 5), 32'hF0 + 32'(k), rb_prev, 0), 101 + 3 * k);
      apply(row(1, 2'b00, 2'b00, 5, 0, 32'hF0, 32'h0, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0,
                rbx(k == 1), 1), 102 + 3 * k);
    end
    apply(row(1, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 1, 1, 2'b00, 2'b00, 0, 27'd0, 32'h0, rbx(1), 0), 106);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
